// File: rtl/fb_axi_pkg.sv
// Shared types for the firebridge host register responder.
package fb_axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  // Only full 32-bit beats map onto registers.
  localparam logic [2:0] SIZE_4B = 3'd2;

endpackage

// File: rtl/fb_axi_reg_slave_if.sv
// AXI4 bus bundle between the host initiator and the register responder.
interface fb_axi_reg_slave_if #(
  parameter int ID_WIDTH   = 6,
  parameter int ADDR_WIDTH = 40
);
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/fb_axi_reg_addr_dec.sv
// Maps a burst address plus beat number onto a register index and flags
// whether that beat may touch the register bank.
module fb_axi_reg_addr_dec
  import fb_axi_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 40,
  parameter int                    N_REGS     = 16,
  parameter int                    IDX_W      = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 40'hA000_0000,
  parameter logic [N_REGS-1:0]     RO_MASK    = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            beat,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [IDX_W-1:0]      idx,
  output logic                  in_range,
  output logic                  ro
);
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word;

  // Full-width word arithmetic so a burst running off the bank never wraps
  // back onto a low register.
  always_comb begin
    offset   = addr - BASE_ADDR;
    word     = (offset >> 2) + ADDR_WIDTH'(beat);
    idx      = word[IDX_W-1:0];
    in_range = (addr >= BASE_ADDR) && (word < ADDR_WIDTH'(N_REGS)) &&
               (size == SIZE_4B) && (burst == INCR);
    ro       = in_range && RO_MASK[idx];
  end
endmodule

// File: rtl/fb_axi_reg_slave.sv
// AXI4 responder for the firebridge host register path: independent write
// (AW/W/B) and read (AR/R) engines over a bank of 32-bit registers.
module fb_axi_reg_slave
  import fb_axi_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 40,
  parameter int                    ID_WIDTH   = 6,
  parameter int                    N_REGS     = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 40'hA000_0000,
  parameter logic [N_REGS-1:0]     RO_MASK    = '0
) (
  input  logic                   clk,
  input  logic                   rstn,
  fb_axi_reg_slave_if.slave      s_axi,
  output logic [N_REGS*32-1:0]   reg_q,
  output logic [N_REGS-1:0]      reg_wr_pulse,
  input  logic [N_REGS*32-1:0]   status_d
);
  localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("fb_axi_reg_slave supports only DATA_WIDTH = 32");
  end

  logic [N_REGS-1:0][31:0] reg_mem;
  logic [N_REGS-1:0][31:0] status_arr;
  assign reg_q      = reg_mem;
  assign status_arr = status_d;

  // Lock/cache/prot carry no meaning for a register bank.
  logic unused_sideband;
  assign unused_sideband = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot,
                             s_axi.arlock, s_axi.arcache, s_axi.arprot};

  // ---------------- write channel ----------------
  wstate_t               w_state, w_state_nxt;
  logic [ID_WIDTH-1:0]   aw_id_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [7:0]            aw_len_q, w_beat_q;
  logic [2:0]            aw_size_q;
  logic [1:0]            aw_burst_q;
  logic                  w_err_q;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_in_range, w_ro, w_ok;
  logic                  aw_fire, w_fire, w_last_beat;

  fb_axi_reg_addr_dec #(
    .ADDR_WIDTH(ADDR_WIDTH), .N_REGS(N_REGS), .IDX_W(IDX_W),
    .BASE_ADDR(BASE_ADDR), .RO_MASK(RO_MASK)
  ) u_wdec (
    .addr(aw_addr_q), .beat(w_beat_q), .size(aw_size_q), .burst(aw_burst_q),
    .idx(w_idx), .in_range(w_in_range), .ro(w_ro)
  );

  assign aw_fire     = s_axi.awvalid && s_axi.awready;
  assign w_fire      = s_axi.wvalid && s_axi.wready;
  assign w_last_beat = (w_beat_q == aw_len_q);
  assign w_ok        = w_in_range && !w_ro;
  assign s_axi.bid   = aw_id_q;
  assign s_axi.bresp = (w_state == W_RESP && w_err_q) ? SLVERR : OKAY;

  // Write FSM state register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) w_state <= W_IDLE;
    else       w_state <= w_state_nxt;
  end

  // Write FSM next state and handshake outputs.
  // NOTE: every output gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    w_state_nxt   = w_state;
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        s_axi.awready = 1'b1;
        if (s_axi.awvalid) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        s_axi.wready = 1'b1;
        if (s_axi.wvalid && w_last_beat) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        s_axi.bvalid = 1'b1;
        if (s_axi.bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Write burst context: captured on AW, advanced per beat, error is sticky.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_beat_q   <= '0;
      w_err_q    <= 1'b0;
    end else if (aw_fire) begin
      aw_id_q    <= s_axi.awid;
      aw_addr_q  <= s_axi.awaddr;
      aw_len_q   <= s_axi.awlen;
      aw_size_q  <= s_axi.awsize;
      aw_burst_q <= s_axi.awburst;
      w_beat_q   <= '0;
      w_err_q    <= 1'b0;
    end else if (w_fire) begin
      w_beat_q <= w_beat_q + 8'd1;
      w_err_q  <= w_err_q | !w_ok | (s_axi.wlast != w_last_beat);
    end
  end

  // Register bank: byte-strobed commit with a pulse aligned to the update.
  // NOTE: the bank is a set of software-visible registers with a defined
  // reset value, so it is reset like any flop rather than left as RAM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      reg_mem      <= '0;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (w_fire && w_ok) begin
        reg_wr_pulse[w_idx] <= 1'b1;
        for (int b = 0; b < 4; b++) begin
          if (s_axi.wstrb[b]) reg_mem[w_idx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
        end
      end
    end
  end

  // ---------------- read channel ----------------
  rstate_t               r_state, r_state_nxt;
  logic [ID_WIDTH-1:0]   ar_id_q;
  logic [ADDR_WIDTH-1:0] ar_addr_q, rd_addr;
  logic [7:0]            ar_len_q, r_beat_q, rd_beat, rd_len;
  logic [2:0]            ar_size_q, rd_size;
  logic [1:0]            ar_burst_q, rd_burst;
  logic [31:0]           r_data_q;
  logic [1:0]            r_resp_q;
  logic                  r_last_q, r_load, ar_fire;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_in_range, r_ro;

  fb_axi_reg_addr_dec #(
    .ADDR_WIDTH(ADDR_WIDTH), .N_REGS(N_REGS), .IDX_W(IDX_W),
    .BASE_ADDR(BASE_ADDR), .RO_MASK(RO_MASK)
  ) u_rdec (
    .addr(rd_addr), .beat(rd_beat), .size(rd_size), .burst(rd_burst),
    .idx(r_idx), .in_range(r_in_range), .ro(r_ro)
  );

  assign ar_fire     = s_axi.arvalid && s_axi.arready;
  assign s_axi.rid   = ar_id_q;
  assign s_axi.rdata = r_data_q;
  assign s_axi.rresp = r_resp_q;
  assign s_axi.rlast = r_last_q;

  // Read FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= R_IDLE;
    else       r_state <= r_state_nxt;
  end

  // Read FSM next state, handshakes and beat-load strobe.
  always_comb begin
    r_state_nxt   = r_state;
    s_axi.arready = 1'b0;
    s_axi.rvalid  = 1'b0;
    r_load        = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        s_axi.arready = 1'b1;
        if (s_axi.arvalid) begin
          r_load      = 1'b1;
          r_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        s_axi.rvalid = 1'b1;
        if (s_axi.rready) begin
          if (r_last_q) r_state_nxt = R_IDLE;
          else          r_load      = 1'b1;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // The first beat decodes straight off AR; later beats off the captured burst.
  always_comb begin
    if (r_state == R_IDLE) begin
      rd_addr  = s_axi.araddr;
      rd_beat  = 8'd0;
      rd_len   = s_axi.arlen;
      rd_size  = s_axi.arsize;
      rd_burst = s_axi.arburst;
    end else begin
      rd_addr  = ar_addr_q;
      rd_beat  = r_beat_q + 8'd1;
      rd_len   = ar_len_q;
      rd_size  = ar_size_q;
      rd_burst = ar_burst_q;
    end
  end

  // Read burst context and the registered R beat, held until accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_beat_q   <= '0;
      r_data_q   <= '0;
      r_resp_q   <= OKAY;
      r_last_q   <= 1'b0;
    end else begin
      if (ar_fire) begin
        ar_id_q    <= s_axi.arid;
        ar_addr_q  <= s_axi.araddr;
        ar_len_q   <= s_axi.arlen;
        ar_size_q  <= s_axi.arsize;
        ar_burst_q <= s_axi.arburst;
      end
      if (r_load) begin
        r_beat_q <= rd_beat;
        r_data_q <= !r_in_range ? 32'd0 : (r_ro ? status_arr[r_idx] : reg_mem[r_idx]);
        r_resp_q <= r_in_range ? OKAY : SLVERR;
        r_last_q <= (rd_beat == rd_len);
      end
    end
  end
endmodule

// File: tb/tb_fb_axi_reg_slave.sv
// Directed bench for fb_axi_reg_slave: single-beat vector table plus
// burst, wlast-error and mid-burst reset sequences.
module tb_fb_axi_reg_slave;
  import fb_axi_pkg::*;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [511:0]  reg_q;
  logic [15:0]   reg_wr_pulse;
  logic [511:0]  status_d;
  int            checks = 0;
  int            failures = 0;
  int            pulse_total = 0;

  logic [31:0]   rd_data [8];
  logic [1:0]    rd_resp [8];
  logic          rd_last [8];

  fb_axi_reg_slave_if #(.ID_WIDTH(6), .ADDR_WIDTH(40)) bus ();

  fb_axi_reg_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(40), .ID_WIDTH(6), .N_REGS(16),
    .BASE_ADDR(40'hA000_0000), .RO_MASK(16'h0008)
  ) dut (
    .clk(clk), .rstn(rstn), .s_axi(bus),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse), .status_d(status_d)
  );

  always #5 clk = ~clk;

  always @(negedge clk) pulse_total += $countones(reg_wr_pulse);

  function automatic logic [31:0] reg_word(input int i);
    return reg_q[i*32 +: 32];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [39:0] addr, input logic [5:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [31:0] data, input logic [3:0] strb,
                           input bit early_last, output logic [1:0] resp, output logic [5:0] bid,
                           output int b_wait);
    int n;
    @(negedge clk);
    bus.awvalid = 1'b1; bus.awaddr = addr; bus.awid = id; bus.awlen = len;
    bus.awsize = size; bus.awburst = 2'b01;
    n = 0;
    while (!bus.awready && n < 20) begin @(negedge clk); n++; end
    check("aw_handshake_in_time", n < 20, 1'b1);
    @(negedge clk);
    bus.awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      bus.wvalid = 1'b1; bus.wdata = data; bus.wstrb = strb;
      bus.wlast = early_last ? (b == 0) : (b == int'(len));
      n = 0;
      while (!bus.wready && n < 20) begin @(negedge clk); n++; end
      check("w_handshake_in_time", n < 20, 1'b1);
      @(negedge clk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    bus.bready = 1'b1;
    n = 0;
    while (!bus.bvalid && n < 20) begin @(negedge clk); n++; end
    check("b_valid_in_time", n < 20, 1'b1);
    b_wait = n; resp = bus.bresp; bid = bus.bid;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [39:0] addr, input logic [5:0] id, input logic [7:0] len,
                          input logic [2:0] size, input bit rand_rdy);
    int n, beat;
    bit rr, have_hold;
    logic [34:0] hold;
    @(negedge clk);
    bus.arvalid = 1'b1; bus.araddr = addr; bus.arid = id; bus.arlen = len;
    bus.arsize = size; bus.arburst = 2'b01;
    n = 0;
    while (!bus.arready && n < 20) begin @(negedge clk); n++; end
    check("ar_handshake_in_time", n < 20, 1'b1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    beat = 0; n = 0; have_hold = 1'b0; hold = '0;
    while (beat <= int'(len) && n < 200) begin
      rr = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.rready = rr;
      if (bus.rvalid) begin
        if (have_hold) check("r_held_stable", {bus.rdata, bus.rresp, bus.rlast}, hold);
        if (rr) begin
          check("rid", bus.rid, id);
          rd_data[beat] = bus.rdata; rd_resp[beat] = bus.rresp; rd_last[beat] = bus.rlast;
          beat++; have_hold = 1'b0;
        end else begin
          hold = {bus.rdata, bus.rresp, bus.rlast}; have_hold = 1'b1;
        end
      end
      @(negedge clk); n++;
    end
    bus.rready = 1'b0;
    check("r_burst_in_time", n < 200, 1'b1);
  endtask

  typedef struct {
    bit          wr;
    logic [39:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs [18];
  logic [1:0]  resp;
  logic [5:0]  bid;
  int          b_wait, p0;

  initial begin
    vecs[0]  = '{1'b1, 40'hA000_0008, 3'd2, 32'hDEAD_BEEF, 4'hF, OKAY,   32'h0};
    vecs[1]  = '{1'b0, 40'hA000_0008, 3'd2, 32'h0,         4'h0, OKAY,   32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 40'hA000_0008, 3'd2, 32'h0000_1234, 4'h3, OKAY,   32'h0};
    vecs[3]  = '{1'b0, 40'hA000_0008, 3'd2, 32'h0,         4'h0, OKAY,   32'hDEAD_1234};
    vecs[4]  = '{1'b1, 40'hA000_000C, 3'd2, 32'h1234_5678, 4'hF, SLVERR, 32'h0};
    vecs[5]  = '{1'b0, 40'hA000_000C, 3'd2, 32'h0,         4'h0, OKAY,   32'h0000_55AA};
    vecs[6]  = '{1'b1, 40'hA000_0038, 3'd2, 32'h1111_1111, 4'hF, OKAY,   32'h0};
    vecs[7]  = '{1'b1, 40'hA000_003C, 3'd2, 32'h2222_2222, 4'hF, OKAY,   32'h0};
    vecs[8]  = '{1'b1, 40'hA000_0040, 3'd2, 32'h3333_3333, 4'hF, SLVERR, 32'h0};
    vecs[9]  = '{1'b1, 40'h9F_FFFF_FFC, 3'd2, 32'h4444_4444, 4'hF, SLVERR, 32'h0};
    vecs[10] = '{1'b0, 40'hA000_0040, 3'd2, 32'h0,         4'h0, SLVERR, 32'h0};
    vecs[11] = '{1'b1, 40'hA000_0005, 3'd2, 32'hAABB_CCDD, 4'hC, OKAY,   32'h0};
    vecs[12] = '{1'b0, 40'hA000_0004, 3'd2, 32'h0,         4'h0, OKAY,   32'hAABB_0000};
    vecs[13] = '{1'b1, 40'hA000_0000, 3'd2, 32'hCAFE_F00D, 4'h4, OKAY,   32'h0};
    vecs[14] = '{1'b0, 40'hA000_0003, 3'd2, 32'h0,         4'h0, OKAY,   32'h00FE_0000};
    vecs[15] = '{1'b1, 40'hA000_0010, 3'd1, 32'h9999_9999, 4'hF, SLVERR, 32'h0};
    vecs[16] = '{1'b0, 40'hA000_0010, 3'd2, 32'h0,         4'h0, OKAY,   32'h0};
    vecs[17] = '{1'b0, 40'hA000_0008, 3'd1, 32'h0,         4'h0, SLVERR, 32'h0};

    status_d = '0;
    status_d[3*32 +: 32] = 32'h0000_55AA;
    status_d[4*32 +: 32] = 32'hBAD0_0004;
    bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0;
    bus.awburst = 0; bus.awlock = 0; bus.awcache = 0; bus.awprot = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
    bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0;
    bus.arburst = 0; bus.arlock = 0; bus.arcache = 0; bus.arprot = 0; bus.rready = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", bus.awready, 1'b1);
    check("rst_arready", bus.arready, 1'b1);
    check("rst_wready", bus.wready, 1'b0);
    check("rst_bvalid", bus.bvalid, 1'b0);
    check("rst_rvalid", bus.rvalid, 1'b0);
    check("rst_reg_q", reg_q, 64'h0);
    check("rst_pulse", reg_wr_pulse, 16'h0);
    rstn = 1'b1;
    @(negedge clk);

    // Single-beat vector table
    for (int i = 0; i < 18; i++) begin
      p0 = pulse_total;
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, 6'(i + 1), 8'd0, vecs[i].size, vecs[i].data, vecs[i].strb,
                  1'b0, resp, bid, b_wait);
        check($sformatf("v%0d_bresp", i), resp, vecs[i].exp_resp);
        check($sformatf("v%0d_bid", i), bid, 6'(i + 1));
        check($sformatf("v%0d_b_latency", i), b_wait, 0);
        check($sformatf("v%0d_pulses", i), pulse_total - p0,
              (vecs[i].exp_resp == OKAY) ? 1 : 0);
      end else begin
        axi_read(vecs[i].addr, 6'(i + 1), 8'd0, vecs[i].size, 1'b0);
        check($sformatf("v%0d_rdata", i), rd_data[0], vecs[i].exp_rd);
        check($sformatf("v%0d_rresp", i), rd_resp[0], vecs[i].exp_resp);
        check($sformatf("v%0d_rlast", i), rd_last[0], 1'b1);
      end
    end
    check("reg2_after_strobe", reg_word(2), 32'hDEAD_1234);
    check("reg3_ro_untouched", reg_word(3), 32'h0);

    // Read burst running off the end of the bank, then with random rready
    for (int pass = 0; pass < 4; pass++) begin
      axi_read(40'hA000_0038, 6'd33, 8'd3, 3'd2, pass != 0);
      check($sformatf("burst%0d_d0", pass), {rd_data[0], rd_resp[0], rd_last[0]}, {32'h1111_1111, OKAY, 1'b0});
      check($sformatf("burst%0d_d1", pass), {rd_data[1], rd_resp[1], rd_last[1]}, {32'h2222_2222, OKAY, 1'b0});
      check($sformatf("burst%0d_d2", pass), {rd_data[2], rd_resp[2], rd_last[2]}, {32'h0, SLVERR, 1'b0});
      check($sformatf("burst%0d_d3", pass), {rd_data[3], rd_resp[3], rd_last[3]}, {32'h0, SLVERR, 1'b1});
      check($sformatf("burst%0d_idle", pass), {bus.rvalid, bus.arready}, 2'b01);
    end

    // Write burst overflowing the bank: first two beats still commit
    p0 = pulse_total;
    axi_write(40'hA000_0038, 6'd40, 8'd3, 3'd2, 32'h7777_7777, 4'hF, 1'b0, resp, bid, b_wait);
    check("wburst_bresp", resp, SLVERR);
    check("wburst_pulses", pulse_total - p0, 2);
    check("wburst_reg14", reg_word(14), 32'h7777_7777);
    check("wburst_reg15", reg_word(15), 32'h7777_7777);

    // Early wlast on a two-beat burst
    axi_write(40'hA000_0020, 6'd41, 8'd1, 3'd2, 32'h0BAD_CAFE, 4'hF, 1'b1, resp, bid, b_wait);
    check("early_wlast_bresp", resp, SLVERR);
    check("early_wlast_idle", {bus.awready, bus.wready, bus.bvalid}, 3'b100);
    axi_write(40'hA000_0020, 6'd42, 8'd0, 3'd2, 32'h0000_0088, 4'hF, 1'b0, resp, bid, b_wait);
    check("after_err_bresp", resp, OKAY);
    check("after_err_reg8", reg_word(8), 32'h0000_0088);

    // Reset asserted mid read burst, after beat 1
    @(negedge clk);
    bus.arvalid = 1'b1; bus.araddr = 40'hA000_0000; bus.arid = 6'd9;
    bus.arlen = 8'd3; bus.arsize = 3'd2; bus.arburst = 2'b01;
    @(negedge clk);
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    check("t6_beat0_valid", bus.rvalid, 1'b1);
    @(negedge clk);
    @(negedge clk);
    bus.rready = 1'b0;
    check("t6_beat2_valid", bus.rvalid, 1'b1);
    rstn = 1'b0;
    #2;
    check("t6_valids", {bus.rvalid, bus.bvalid, bus.wready}, 3'b000);
    check("t6_readies", {bus.awready, bus.arready}, 2'b11);
    check("t6_rdata", bus.rdata, 32'h0);
    check("t6_reg_q_lo", reg_q[255:0] == '0, 1'b1);
    check("t6_reg_q_hi", reg_q[511:256] == '0, 1'b1);
    @(negedge clk);
    rstn = 1'b1;
    axi_write(40'hA000_0014, 6'd50, 8'd0, 3'd2, 32'h5A5A_5A5A, 4'hF, 1'b0, resp, bid, b_wait);
    check("t6_write_bresp", resp, OKAY);
    check("t6_write_bid", bid, 6'd50);
    axi_read(40'hA000_0014, 6'd51, 8'd0, 3'd2, 1'b0);
    check("t6_read_data", rd_data[0], 32'h5A5A_5A5A);
    check("t6_read_resp", rd_resp[0], OKAY);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
